// File: rtl/aibcr3aux_osc_pkg.sv
// Shared types and constants for the AIB aux oscillator post-processor.
// The ratio helper gives the full divided-clock period in oscillator cycles.
package aibcr3aux_osc_pkg;

    localparam int SETTLE_CYC_DEFAULT = 1024;
    localparam int DIV_W_DEFAULT      = 4;

    typedef enum logic [1:0] {
        OSC_OFF    = 2'd0,
        OSC_SETTLE = 2'd1,
        OSC_RUN    = 2'd2
    } osc_state_e;

    function automatic int div_ratio(input int sel);
        return 2 * (sel + 1);
    endfunction

endpackage

// File: rtl/aibcr3aux_osc_clkdiv.sv
// Oscillator settle timer, programmable 50% clock divider and glitch-free
// divide-ratio handshake, all running on the raw oscillator clock.
module aibcr3aux_osc_clkdiv
    import aibcr3aux_osc_pkg::*;
#(
    parameter int SETTLE_CYC = SETTLE_CYC_DEFAULT,
    parameter int DIV_W      = DIV_W_DEFAULT
) (
    input  logic             osc_clk,
    input  logic             osc_reset,
    input  logic             osc_en,
    input  logic             chicken_bit,
    input  logic [DIV_W-1:0] div_sel,
    input  logic             div_req,
    output logic             div_ack,
    output logic             div_clk,
    output logic             div_tick,
    output logic             osc_rdy
);

    localparam int            SW          = $clog2(SETTLE_CYC);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

    osc_state_e       state;
    osc_state_e       next_state;
    logic [SW-1:0]    settle_cnt;
    logic [SW-1:0]    settle_cnt_d;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_cnt_d;
    logic [DIV_W-1:0] div_sel_q;
    logic [DIV_W-1:0] div_sel_q_d;
    logic             div_clk_d;
    logic             div_tick_d;
    logic             osc_rdy_d;
    logic             div_ack_d;
    logic             phase_end;
    logic             capture;

    always_ff @(posedge osc_clk or posedge osc_reset) begin
        if (osc_reset) begin
            state <= OSC_OFF;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (!osc_en) begin
            next_state = OSC_OFF;
        end else begin
            case (state)
                OSC_OFF:    next_state = OSC_SETTLE;
                OSC_SETTLE: begin
                    if (chicken_bit || (settle_cnt == SETTLE_LAST)) begin
                        next_state = OSC_RUN;
                    end
                end
                OSC_RUN:    next_state = OSC_RUN;
                default:    next_state = OSC_OFF;
            endcase
        end
    end

    // The divider only advances once osc_rdy is already high, which delays
    // the first div_clk rise by a full half period after osc_rdy rises.
    always_comb begin
        settle_cnt_d = settle_cnt;
        div_cnt_d    = div_cnt;
        div_clk_d    = div_clk;
        div_tick_d   = 1'b0;
        osc_rdy_d    = 1'b0;
        div_sel_q_d  = div_sel_q;
        div_ack_d    = 1'b0;
        phase_end    = osc_rdy && (div_cnt == div_sel_q);
        capture      = div_req && !div_ack &&
                       ((state != OSC_RUN) || (osc_en && phase_end && div_clk));

        if (!osc_en) begin
            settle_cnt_d = '0;
            div_cnt_d    = '0;
            div_clk_d    = 1'b0;
        end else begin
            case (state)
                OSC_OFF: begin
                    settle_cnt_d = '0;
                    div_cnt_d    = '0;
                    div_clk_d    = 1'b0;
                    div_sel_q_d  = div_sel;
                end
                OSC_SETTLE: begin
                    div_cnt_d = '0;
                    div_clk_d = 1'b0;
                    if (next_state == OSC_SETTLE) begin
                        settle_cnt_d = settle_cnt + 1'b1;
                    end
                end
                OSC_RUN: begin
                    osc_rdy_d = 1'b1;
                    if (osc_rdy) begin
                        if (phase_end) begin
                            div_cnt_d  = '0;
                            div_clk_d  = !div_clk;
                            div_tick_d = !div_clk;
                        end else begin
                            div_cnt_d = div_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        // Captures in RUN land only on a falling div_clk edge, so a new
        // ratio always starts on a fresh low phase.
        if (capture) begin
            div_sel_q_d = div_sel;
            div_ack_d   = 1'b1;
        end
    end

    always_ff @(posedge osc_clk or posedge osc_reset) begin
        if (osc_reset) begin
            settle_cnt <= '0;
            div_cnt    <= '0;
            div_sel_q  <= '0;
            div_clk    <= 1'b0;
            div_tick   <= 1'b0;
            osc_rdy    <= 1'b0;
            div_ack    <= 1'b0;
        end else begin
            settle_cnt <= settle_cnt_d;
            div_cnt    <= div_cnt_d;
            div_sel_q  <= div_sel_q_d;
            div_clk    <= div_clk_d;
            div_tick   <= div_tick_d;
            osc_rdy    <= osc_rdy_d;
            div_ack    <= div_ack_d;
        end
    end

endmodule

// File: tb/tb_aibcr3aux_osc_clkdiv.sv
// Self-checking bench for aibcr3aux_osc_clkdiv: directed scenarios plus a
// randomized run, compared every cycle against an event-time reference model.
module tb_aibcr3aux_osc_clkdiv;
    import aibcr3aux_osc_pkg::*;

    localparam int SETTLE = 16;
    localparam int DW     = 4;

    logic          osc_clk = 1'b0;
    logic          osc_reset = 1'b0;
    logic          osc_en = 1'b0;
    logic          chicken_bit = 1'b0;
    logic [DW-1:0] div_sel = '0;
    logic          div_req = 1'b0;
    logic          div_ack;
    logic          div_clk;
    logic          div_tick;
    logic          osc_rdy;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model: tracks the ready edge and next toggle edge in
    // absolute edge numbers rather than counters.
    int edge_no = 0;
    bit m_prev_en = 1'b0;
    int m_rdy_at = 0;
    int m_next_toggle = 0;
    int m_sel = 0;
    bit m_clk = 1'b0;
    bit m_tick = 1'b0;
    bit m_rdy = 1'b0;
    bit m_ack = 1'b0;

    aibcr3aux_osc_clkdiv #(
        .SETTLE_CYC(SETTLE),
        .DIV_W     (DW)
    ) dut (
        .osc_clk    (osc_clk),
        .osc_reset  (osc_reset),
        .osc_en     (osc_en),
        .chicken_bit(chicken_bit),
        .div_sel    (div_sel),
        .div_req    (div_req),
        .div_ack    (div_ack),
        .div_clk    (div_clk),
        .div_tick   (div_tick),
        .osc_rdy    (osc_rdy)
    );

    always #5 osc_clk = ~osc_clk;

    task automatic checkOutput(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit en, input bit chk, input bit req, input int sel);
        osc_en      = en;
        chicken_bit = chk;
        div_req     = req;
        div_sel     = DW'(sel);
    endtask

    task automatic modelReset();
        m_prev_en = 1'b0;
        m_sel     = 0;
        m_clk     = 1'b0;
        m_tick    = 1'b0;
        m_rdy     = 1'b0;
        m_ack     = 1'b0;
    endtask

    task automatic modelEdge();
        int ps;
        bit new_ack;
        bit new_tick;
        edge_no++;
        if (!m_prev_en)           ps = 0;
        else if (edge_no < m_rdy_at) ps = 1;
        else                      ps = 2;
        new_ack  = 1'b0;
        new_tick = 1'b0;
        if (ps != 2 && div_req && !m_ack) begin
            m_sel   = int'(div_sel);
            new_ack = 1'b1;
        end
        if (ps == 0 && osc_en) m_sel = int'(div_sel);
        if (!osc_en) begin
            m_clk = 1'b0;
            m_rdy = 1'b0;
        end else if (ps == 0) begin
            m_rdy_at = edge_no + (chicken_bit ? 2 : SETTLE + 1);
            m_clk    = 1'b0;
            m_rdy    = 1'b0;
        end else if (ps == 2) begin
            m_rdy = 1'b1;
            if (edge_no == m_rdy_at) begin
                m_next_toggle = edge_no + m_sel + 1;
            end else if (edge_no == m_next_toggle) begin
                new_tick = !m_clk;
                if (m_clk && div_req && !m_ack) begin
                    m_sel   = int'(div_sel);
                    new_ack = 1'b1;
                end
                m_clk         = !m_clk;
                m_next_toggle = edge_no + m_sel + 1;
            end
        end
        m_tick    = new_tick;
        m_ack     = new_ack;
        m_prev_en = osc_en;
    endtask

    // One oscillator edge: advance the model, sample #1 later, then let the
    // requester drop div_req once it has seen the ack.
    task automatic stepCycle();
        @(posedge osc_clk);
        modelEdge();
        #1;
        checkOutput("div_clk",  int'(div_clk),  int'(m_clk));
        checkOutput("div_tick", int'(div_tick), int'(m_tick));
        checkOutput("osc_rdy",  int'(osc_rdy),  int'(m_rdy));
        checkOutput("div_ack",  int'(div_ack),  int'(m_ack));
        if (div_req && div_ack) div_req = 1'b0;
    endtask

    task automatic measureRdy(input int exp_lat, input string tag);
        int n;
        stepCycle();
        n = 0;
        while (!osc_rdy && n < 2000) begin
            stepCycle();
            n++;
        end
        checkOutput(tag, n, exp_lat);
    endtask

    task automatic measureHalf(input int sel, input string tag);
        int n;
        int hi;
        int lo;
        n = 0;
        while (!div_tick && n < 100) begin
            stepCycle();
            n++;
        end
        checkOutput({tag, "_tick_seen"}, int'(div_tick), 1);
        hi = 1;
        stepCycle();
        while (div_clk && hi < 100) begin
            hi++;
            stepCycle();
        end
        lo = 1;
        stepCycle();
        while (!div_clk && lo < 100) begin
            lo++;
            stepCycle();
        end
        checkOutput({tag, "_high"}, hi, sel + 1);
        checkOutput({tag, "_low"}, lo, sel + 1);
        checkOutput({tag, "_period"}, hi + lo, div_ratio(sel));
    endtask

    task automatic waitAck(input string tag, output bit clk_before);
        int n;
        bit prev;
        n = 0;
        prev = div_clk;
        clk_before = 1'b0;
        while (!div_ack && n < 200) begin
            prev = div_clk;
            stepCycle();
            n++;
        end
        clk_before = prev;
        checkOutput(tag, int'(div_ack), 1);
    endtask

    initial begin
        bit cb;
        int lo;
        int n;

        #2 osc_reset = 1'b1;
        modelReset();
        #1;
        checkOutput("rst_div_clk",  int'(div_clk),  0);
        checkOutput("rst_div_tick", int'(div_tick), 0);
        checkOutput("rst_osc_rdy",  int'(osc_rdy),  0);
        checkOutput("rst_div_ack",  int'(div_ack),  0);
        repeat (2) @(posedge osc_clk);
        #1 osc_reset = 1'b0;
        stepCycle();

        $display("[TB] settle window, ratio 2");
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        measureRdy(SETTLE + 1, "rdy_lat_settle");
        measureHalf(0, "sel0");
        measureHalf(0, "sel0b");

        $display("[TB] chicken bit, ratio 8");
        applyStimulus(1'b0, 1'b0, 1'b0, 0);
        repeat (2) stepCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 3);
        measureRdy(2, "rdy_lat_chicken");
        measureHalf(3, "sel3");

        $display("[TB] ratio change mid-low phase");
        n = 0;
        while (div_clk && n < 20) begin
            stepCycle();
            n++;
        end
        stepCycle();
        div_req = 1'b1;
        div_sel = DW'(1);
        waitAck("hs_ack_seen", cb);
        checkOutput("hs_clk_before_ack", int'(cb), 1);
        checkOutput("hs_clk_at_ack", int'(div_clk), 0);
        lo = 1;
        stepCycle();
        while (!div_clk && lo < 100) begin
            lo++;
            stepCycle();
        end
        checkOutput("hs_new_low", lo, 2);
        measureHalf(1, "sel1");

        $display("[TB] enable drop mid-high phase");
        n = 0;
        while (!div_tick && n < 20) begin
            stepCycle();
            n++;
        end
        osc_en = 1'b0;
        stepCycle();
        checkOutput("drop_div_clk", int'(div_clk), 0);
        checkOutput("drop_osc_rdy", int'(osc_rdy), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        measureRdy(SETTLE + 1, "rdy_lat_reenable");

        $display("[TB] reset mid-run with request held");
        repeat (3) stepCycle();
        div_req = 1'b1;
        div_sel = DW'(5);
        #2 osc_reset = 1'b1;
        #1;
        modelReset();
        checkOutput("arst_div_clk", int'(div_clk), 0);
        checkOutput("arst_osc_rdy", int'(osc_rdy), 0);
        checkOutput("arst_div_ack", int'(div_ack), 0);
        repeat (2) @(posedge osc_clk);
        #1 osc_reset = 1'b0;
        stepCycle();
        checkOutput("rerun_ack", int'(div_ack), 1);

        $display("[TB] maximum ratio");
        n = 0;
        while (!osc_rdy && n < 100) begin
            stepCycle();
            n++;
        end
        div_req = 1'b1;
        div_sel = DW'(15);
        waitAck("max_ack_seen", cb);
        measureHalf(15, "sel15");

        $display("[TB] randomized run");
        for (int i = 0; i < 4000; i++) begin
            stepCycle();
            if ($urandom_range(0, 199) == 0) begin
                osc_en = !osc_en;
            end
            if (!osc_en && $urandom_range(0, 3) == 0) begin
                chicken_bit = 1'($urandom_range(0, 1));
            end
            if (!div_req) begin
                if ($urandom_range(0, 15) == 0) begin
                    div_req = 1'b1;
                    div_sel = DW'($urandom_range(0, 15));
                end
            end else begin
                if ($urandom_range(0, 15) == 0) div_sel = DW'($urandom_range(0, 15));
                if ($urandom_range(0, 63) == 0) div_req = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
